wb_dmi_bridge: RTL and testbench



---
 rtl/dm_pkg.sv | 15 +
 rtl/wb_dmi_pkg.sv | 23 ++
 rtl/wb_if.sv | 23 ++
 rtl/wb_dmi_bridge.sv | 170 +++++++++++++++++
 tb/tb_wb_dmi_bridge.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/dm_pkg.sv
// DMI request/response payloads shared with the debug module.
package dm;

  typedef struct packed {
    logic [6:0]  addr;
    logic [1:0]  op;
    logic [31:0] data;
  } dmi_req_t;

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  resp;
  } dmi_resp_t;

endpackage

// File: rtl/wb_dmi_pkg.sv
// Shared types for the Wishbone-to-DMI bridge: FSM states, DMI op and response codes.
package wb_dmi_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2,
    DONE = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    DMI_NOP   = 2'd0,
    DMI_READ  = 2'd1,
    DMI_WRITE = 2'd2
  } dmi_op_e;

  typedef enum logic [1:0] {
    DMI_SUCCESS = 2'd0,
    DMI_FAILED  = 2'd2,
    DMI_BUSY    = 2'd3
  } dmi_resp_e;

endpackage

// File: rtl/wb_if.sv
// Pipelined Wishbone bus, 32-bit data and address.
interface wb_if;
  logic        cyc;
  logic        stb;
  logic        we;
  logic [3:0]  sel;
  logic [31:0] adr;
  logic [31:0] dat_m;
  logic [31:0] dat_s;
  logic        ack;
  logic        err;
  logic        stall;

  modport slave (
    input  cyc, stb, we, sel, adr, dat_m,
    output dat_s, ack, err, stall
  );

  modport master (
    output cyc, stb, we, sel, adr, dat_m,
    input  dat_s, ack, err, stall
  );
endinterface

// File: rtl/wb_dmi_bridge.sv
// Wishbone pipelined slave issuing one DMI request/response per bus access.
// Optional response timeout with DMI flush is enabled by defining WB_DMI_TIMEOUT_EN.
module wb_dmi_bridge
  import wb_dmi_pkg::*;
#(
  parameter int unsigned AddrLsb       = 2,
  parameter int unsigned DmiAddrWidth  = 7,
  parameter int unsigned TimeoutCycles = 1024
) (
  input  logic          clk,
  input  logic          rst,
  wb_if.slave           wbs,
  output logic          dmi_rst_n,
  output logic          dmi_req_valid,
  input  logic          dmi_req_ready,
  output dm::dmi_req_t  dmi_req,
  input  logic          dmi_resp_valid,
  output logic          dmi_resp_ready,
  input  dm::dmi_resp_t dmi_resp
);

  localparam int unsigned CntW = $clog2(TimeoutCycles + 1);

  state_e       r_state, w_state_nxt;
  dm::dmi_req_t r_req, w_req_nxt;
  logic         r_req_valid, w_req_valid_nxt;
  logic         r_resp_ready, w_resp_ready_nxt;
  logic         r_ack, w_ack_nxt;
  logic         r_err, w_err_nxt;
  logic [31:0]  r_dat, w_dat_nxt;
  logic         r_stall, w_stall_nxt;
  logic         r_abort, w_abort_nxt;
  logic [1:0]   r_sync;
  logic         w_flush;
  logic         w_timeout;
  logic         w_ok;
  logic         w_rst_n_nxt;
  logic         w_unused;

  // Byte lanes and out-of-field address bits have no DMI meaning.
  assign w_unused = ^{wbs.sel, wbs.adr};

`ifdef WB_DMI_TIMEOUT_EN
  logic [CntW-1:0] r_cnt;

  // Cleared while idle, so it restarts from zero on every entry into REQ.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (r_state == IDLE) begin
      r_cnt <= '0;
    end else if (r_state == REQ || r_state == RESP) begin
      r_cnt <= r_cnt + CntW'(1);
    end
  end

  assign w_timeout = (r_state == REQ || r_state == RESP) && (r_cnt == CntW'(TimeoutCycles));
`else
  logic [CntW-1:0] w_unused_cnt;
  assign w_unused_cnt = '0;
  assign w_timeout    = 1'b0;
`endif

  // Master still wants the result: cycle held and never dropped during the access.
  assign w_ok        = wbs.cyc && !r_abort;
  assign w_rst_n_nxt = w_flush ? 1'b0 : r_sync[0];

  always_comb begin
    w_state_nxt      = r_state;
    w_req_nxt        = r_req;
    w_req_valid_nxt  = 1'b0;
    w_resp_ready_nxt = 1'b0;
    w_ack_nxt        = 1'b0;
    w_err_nxt        = 1'b0;
    w_dat_nxt        = r_dat;
    w_abort_nxt      = r_abort;
    w_flush          = 1'b0;

    unique case (r_state)
      IDLE: begin
        w_abort_nxt = 1'b0;
        if (!r_stall && wbs.cyc && wbs.stb) begin
          w_state_nxt     = REQ;
          w_req_nxt.addr  = wbs.adr[AddrLsb +: DmiAddrWidth];
          w_req_nxt.op    = wbs.we ? DMI_WRITE : DMI_READ;
          w_req_nxt.data  = wbs.dat_m;
          w_req_valid_nxt = 1'b1;
        end
      end
      REQ: begin
        if (!wbs.cyc) w_abort_nxt = 1'b1;
        if (w_timeout) begin
          w_state_nxt = DONE;
          w_err_nxt   = w_ok;
          w_dat_nxt   = '0;
          w_flush     = 1'b1;
        end else if (dmi_req_ready) begin
          w_state_nxt      = RESP;
          w_resp_ready_nxt = 1'b1;
        end else begin
          w_req_valid_nxt = 1'b1;
        end
      end
      RESP: begin
        if (!wbs.cyc) w_abort_nxt = 1'b1;
        if (w_timeout) begin
          w_state_nxt = DONE;
          w_err_nxt   = w_ok;
          w_dat_nxt   = '0;
          w_flush     = 1'b1;
        end else if (dmi_resp_valid) begin
          w_state_nxt = DONE;
          if (dmi_resp.resp == DMI_SUCCESS) begin
            w_ack_nxt = w_ok;
            w_dat_nxt = dmi_resp.data;
          end else begin
            w_err_nxt = w_ok;
            w_dat_nxt = '0;
          end
        end else begin
          w_resp_ready_nxt = 1'b1;
        end
      end
      DONE: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase

    w_stall_nxt = !((w_state_nxt == IDLE) && w_rst_n_nxt);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_req        <= '0;
      r_req_valid  <= 1'b0;
      r_resp_ready <= 1'b0;
      r_ack        <= 1'b0;
      r_err        <= 1'b0;
      r_dat        <= '0;
      r_stall      <= 1'b1;
      r_abort      <= 1'b0;
      r_sync       <= 2'b00;
    end else begin
      r_state      <= w_state_nxt;
      r_req        <= w_req_nxt;
      r_req_valid  <= w_req_valid_nxt;
      r_resp_ready <= w_resp_ready_nxt;
      r_ack        <= w_ack_nxt;
      r_err        <= w_err_nxt;
      r_dat        <= w_dat_nxt;
      r_stall      <= w_stall_nxt;
      r_abort      <= w_abort_nxt;
      r_sync       <= w_flush ? 2'b00 : {r_sync[0], 1'b1};
    end
  end

  assign dmi_rst_n      = r_sync[1];
  assign dmi_req_valid  = r_req_valid;
  assign dmi_req        = r_req;
  assign dmi_resp_ready = r_resp_ready;
  assign wbs.ack        = r_ack;
  assign wbs.err        = r_err;
  assign wbs.dat_s      = r_dat;
  assign wbs.stall      = r_stall;

endmodule

// File: tb/tb_wb_dmi_bridge.sv
// Self-checking bench for wb_dmi_bridge: directed cases plus random accesses vs. a reference model.
module tb_wb_dmi_bridge;

`ifdef WB_DMI_TIMEOUT_EN
  localparam int unsigned TO = 16;
`else
  localparam int unsigned TO = 1024;
`endif

  logic          clk;
  logic          rst;
  logic          dmi_rst_n;
  logic          dmi_req_valid;
  logic          dmi_req_ready;
  dm::dmi_req_t  dmi_req;
  logic          dmi_resp_valid;
  logic          dmi_resp_ready;
  dm::dmi_resp_t dmi_resp;

  int total = 0;
  int bad   = 0;

  wb_if u_wb ();

  wb_dmi_bridge #(
    .AddrLsb       (2),
    .DmiAddrWidth  (7),
    .TimeoutCycles (TO)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .wbs            (u_wb),
    .dmi_rst_n      (dmi_rst_n),
    .dmi_req_valid  (dmi_req_valid),
    .dmi_req_ready  (dmi_req_ready),
    .dmi_req        (dmi_req),
    .dmi_resp_valid (dmi_resp_valid),
    .dmi_resp_ready (dmi_resp_ready),
    .dmi_resp       (dmi_resp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: word address bits 8:2 become the DMI address, write/read map to ops 2/1.
  function automatic logic [63:0] model_req(input logic we, input logic [31:0] adr,
                                            input logic [31:0] wdat);
    logic [63:0] v;
    logic [6:0]  a;
    logic [1:0]  op;
    a  = 7'((adr / 32'd4) % 32'd128);
    op = we ? 2'd2 : 2'd1;
    v  = {23'd0, a, op, wdat};
    return v;
  endfunction

  // One bus access, DMI side stalls req_wait cycles on request and resp_wait on response.
  task automatic do_txn(input logic we, input logic [31:0] adr, input logic [31:0] wdat,
                        input logic [3:0] sel, input int req_wait, input int resp_wait,
                        input logic [31:0] rdat, input logic [1:0] rcode, input logic abort);
    logic [63:0] exp_req;
    logic        exp_ack;
    logic        exp_err;
    logic [31:0] exp_dat;
    exp_req = model_req(we, adr, wdat);
    exp_ack = !abort && (rcode == 2'd0);
    exp_err = !abort && (rcode != 2'd0);
    exp_dat = (rcode == 2'd0) ? rdat : 32'd0;

    chk("idle_stall", 64'(u_wb.stall), 64'd0);
    u_wb.cyc = 1'b1; u_wb.stb = 1'b1; u_wb.we = we;
    u_wb.adr = adr; u_wb.dat_m = wdat; u_wb.sel = sel;
    tick();
    u_wb.stb = 1'b0;
    chk("req_valid", 64'(dmi_req_valid), 64'd1);
    chk("req_fields", 64'(dmi_req), exp_req);
    chk("busy_stall", 64'(u_wb.stall), 64'd1);
    for (int i = 0; i < req_wait; i++) begin
      tick();
      chk("req_hold_valid", 64'(dmi_req_valid), 64'd1);
      chk("req_hold_fields", 64'(dmi_req), exp_req);
      chk("req_hold_stall", 64'(u_wb.stall), 64'd1);
    end
    dmi_req_ready = 1'b1;
    tick();
    dmi_req_ready = 1'b0;
    chk("req_drop", 64'(dmi_req_valid), 64'd0);
    chk("resp_ready", 64'(dmi_resp_ready), 64'd1);
    if (abort) u_wb.cyc = 1'b0;
    for (int i = 0; i < resp_wait; i++) begin
      tick();
      chk("resp_wait_ready", 64'(dmi_resp_ready), 64'd1);
      chk("resp_wait_noack", 64'({u_wb.ack, u_wb.err}), 64'd0);
      chk("resp_wait_stall", 64'(u_wb.stall), 64'd1);
    end
    dmi_resp_valid = 1'b1;
    dmi_resp.data  = rdat;
    dmi_resp.resp  = rcode;
    tick();
    dmi_resp_valid = 1'b0;
    chk("done_ack", 64'(u_wb.ack), 64'(exp_ack));
    chk("done_err", 64'(u_wb.err), 64'(exp_err));
    if (!abort) chk("done_dat", 64'(u_wb.dat_s), 64'(exp_dat));
    chk("done_stall", 64'(u_wb.stall), 64'd1);
    chk("done_resp_ready", 64'(dmi_resp_ready), 64'd0);
    tick();
    chk("pulse_end", 64'({u_wb.ack, u_wb.err}), 64'd0);
    chk("back_idle", 64'(u_wb.stall), 64'd0);
    u_wb.cyc = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r_adr;
    logic [31:0] r_dat;
    logic [1:0]  r_code;
    int          idx;

    rst = 1'b1;
    u_wb.cyc = 1'b0; u_wb.stb = 1'b0; u_wb.we = 1'b0; u_wb.sel = 4'h0;
    u_wb.adr = '0; u_wb.dat_m = '0;
    dmi_req_ready = 1'b0; dmi_resp_valid = 1'b0; dmi_resp = '0;
    #1;
    chk("rst_ack", 64'(u_wb.ack), 64'd0);
    chk("rst_err", 64'(u_wb.err), 64'd0);
    chk("rst_dat", 64'(u_wb.dat_s), 64'd0);
    chk("rst_stall", 64'(u_wb.stall), 64'd1);
    chk("rst_req_valid", 64'(dmi_req_valid), 64'd0);
    chk("rst_resp_ready", 64'(dmi_resp_ready), 64'd0);
    chk("rst_req", 64'(dmi_req), 64'd0);
    chk("rst_dmi_rst_n", 64'(dmi_rst_n), 64'd0);
    tick(); tick();
    rst = 1'b0;
    tick();
    chk("sync_edge1", 64'(dmi_rst_n), 64'd0);
    chk("sync_edge1_stall", 64'(u_wb.stall), 64'd1);
    tick();
    chk("sync_edge2", 64'(dmi_rst_n), 64'd1);
    chk("sync_edge2_stall", 64'(u_wb.stall), 64'd0);

    // Read of dmstatus, zero-wait DMI: ack lands three cycles after stb.
    do_txn(1'b0, 32'h44, 32'h0, 4'hF, 0, 0, 32'h00400C82, 2'd0, 1'b0);
    // Write with request backpressure and partial byte select.
    do_txn(1'b1, 32'h40, 32'h1, 4'h3, 5, 0, 32'hDEADBEEF, 2'd0, 1'b0);
    // Busy response becomes a bus error with zero data.
    do_txn(1'b0, 32'h44, 32'h0, 4'hF, 0, 1, 32'h12345678, 2'd3, 1'b0);
    // Abort in RESP, then a normal read.
    do_txn(1'b0, 32'h10, 32'h0, 4'hF, 1, 2, 32'hCAFEF00D, 2'd0, 1'b1);
    do_txn(1'b0, 32'hFFFF_FE0C, 32'h0, 4'hF, 0, 0, 32'h0000_00A5, 2'd0, 1'b0);

    // Stray response while idle.
    dmi_resp_valid = 1'b1; dmi_resp.data = 32'h55AA55AA; dmi_resp.resp = 2'd0;
    tick();
    dmi_resp_valid = 1'b0;
    chk("stray_resp_ack", 64'({u_wb.ack, u_wb.err}), 64'd0);
    chk("stray_resp_ready", 64'(dmi_resp_ready), 64'd0);
    chk("stray_resp_stall", 64'(u_wb.stall), 64'd0);

    for (int n = 0; n < 24; n++) begin
      r_adr  = $urandom;
      r_dat  = $urandom;
      idx    = int'($urandom_range(0, 2));
      r_code = (idx == 0) ? 2'd0 : 2'(idx + 1);
      do_txn(1'($urandom_range(0, 1)), r_adr, $urandom, 4'($urandom_range(0, 15)),
             int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), r_dat, r_code,
             ($urandom_range(0, 5) == 0));
    end

    // Reset asserted while a request is pending.
    u_wb.cyc = 1'b1; u_wb.stb = 1'b1; u_wb.we = 1'b1; u_wb.adr = 32'h40; u_wb.dat_m = 32'h3;
    tick();
    u_wb.stb = 1'b0;
    chk("pre_rst_valid", 64'(dmi_req_valid), 64'd1);
    rst = 1'b1;
    #1;
    chk("async_rst_valid", 64'(dmi_req_valid), 64'd0);
    chk("async_rst_stall", 64'(u_wb.stall), 64'd1);
    chk("async_rst_dmi_rst_n", 64'(dmi_rst_n), 64'd0);
    chk("async_rst_req", 64'(dmi_req), 64'd0);
    u_wb.cyc = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    chk("rel_edge1", 64'(dmi_rst_n), 64'd0);
    tick();
    chk("rel_edge2", 64'(dmi_rst_n), 64'd1);
    chk("rel_stall", 64'(u_wb.stall), 64'd0);
    do_txn(1'b0, 32'h44, 32'h0, 4'hF, 0, 0, 32'h00400C82, 2'd0, 1'b0);

`ifdef WB_DMI_TIMEOUT_EN
    // DMI never answers: error on cycle TO+2 and a two-cycle DMI reset.
    u_wb.cyc = 1'b1; u_wb.stb = 1'b1; u_wb.we = 1'b0; u_wb.adr = 32'h44;
    tick();
    u_wb.stb = 1'b0;
    for (int c = 2; c <= int'(TO) + 1; c++) begin
      tick();
      chk("to_wait_err", 64'(u_wb.err), 64'd0);
      chk("to_wait_valid", 64'(dmi_req_valid), 64'd1);
    end
    tick();
    chk("to_err", 64'(u_wb.err), 64'd1);
    chk("to_ack", 64'(u_wb.ack), 64'd0);
    chk("to_dat", 64'(u_wb.dat_s), 64'd0);
    chk("to_flush0", 64'(dmi_rst_n), 64'd0);
    tick();
    chk("to_err_end", 64'(u_wb.err), 64'd0);
    chk("to_flush1", 64'(dmi_rst_n), 64'd0);
    dmi_resp_valid = 1'b1; dmi_resp.data = 32'h77; dmi_resp.resp = 2'd0;
    tick();
    dmi_resp_valid = 1'b0;
    chk("to_release", 64'(dmi_rst_n), 64'd1);
    chk("to_late_resp", 64'({u_wb.ack, u_wb.err}), 64'd0);
    chk("to_idle", 64'(u_wb.stall), 64'd0);
    u_wb.cyc = 1'b0;
    do_txn(1'b1, 32'h40, 32'h1, 4'hF, 0, 0, 32'h0, 2'd0, 1'b0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
